// File: rtl/mem_stage_pkg.sv
// Shared ISA opcodes, datapath parameters and MEM-stage helpers.
package mem_stage_pkg;

    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 64;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_LW   = 6'h10;
    localparam logic [5:0] OP_LH   = 6'h11;
    localparam logic [5:0] OP_LD   = 6'h12;
    localparam logic [5:0] OP_SW   = 6'h18;
    localparam logic [5:0] OP_SH   = 6'h19;
    localparam logic [5:0] OP_SD   = 6'h1A;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [DATA_W-1:0] MEM_NOP = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_mem(input logic [5:0] op);
        return op inside {OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SH, OP_SD};
    endfunction

    function automatic logic is_half(input logic [5:0] op);
        return (op == OP_LH) || (op == OP_SH);
    endfunction

    function automatic logic is_dword(input logic [5:0] op);
        return (op == OP_LD) || (op == OP_SD);
    endfunction

    function automatic logic aligned(input logic [5:0] op, input logic [2:0] a);
        logic ok;
        ok = 1'b1;
        if ((op == OP_LW) || (op == OP_SW)) ok = (a[1:0] == 2'b00);
        else if (is_half(op))               ok = !a[0];
        else if (is_dword(op))              ok = (a == 3'b000);
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and memory.
interface mem_stage_if #(
    parameter int WIDTH = 32
) ();
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane steering: byte enables, store data replication, load extraction.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [5:0]       op,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] rdata,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] ld_data
);
    logic [15:0] half;

    always_comb begin
        half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be      = 4'b1111;
        wdata   = z;
        ld_data = rdata;
        if (is_half(op)) begin
            // aligned halves only reach here, so the shift is 0 or 2 lanes
            be      = 4'b0011 << addr_lo;
            wdata   = {(WIDTH/16){z[15:0]}};
            ld_data = {{(WIDTH-16){half[15]}}, half};
        end
    end
endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU results through, runs loads/stores over a req/ack port.
//   state | meaning
//   IDLE  | accept next op; non-memory ops register straight through
//   BEAT0 | first (or only) word access outstanding
//   BEAT1 | second word of LD/SD at Addr+4
//   DONE  | results visible to writeback, upstream released
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int TIMEOUT = TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] IR_in,
    input  logic [WIDTH-3:0] PC_in,
    input  logic [WIDTH-1:0] Z_in,
    input  logic [WIDTH-1:0] Addr_in,
    mem_stage_if.master      mem,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-3:0] PC_out,
    output logic [WIDTH-1:0] Z_out,
    output logic [WIDTH-1:0] Z_hi,
    output logic             IsStall,
    output logic             MemErr
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] ir_q, z_q, addr_q, lo_q;
    logic [WIDTH-3:0] pc_q;
    logic [CW-1:0]    cnt;
    logic [5:0]       op_in, op_q;
    logic             busy, acc_ok, acc_bad, tmo;
    logic [3:0]       be;
    logic [WIDTH-1:0] wdata, ld_data;

    assign op_in   = IR_in[WIDTH-1 -: 6];
    assign op_q    = ir_q[WIDTH-1 -: 6];
    assign busy    = (state == ST_BEAT0) || (state == ST_BEAT1);
    assign acc_ok  = (state == ST_IDLE) && is_mem(op_in) && aligned(op_in, Addr_in[2:0]);
    assign acc_bad = (state == ST_IDLE) && is_mem(op_in) && !aligned(op_in, Addr_in[2:0]);
    assign tmo     = busy && !mem.mem_ack && (cnt == CW'(TIMEOUT - 1));

    mem_align #(.WIDTH(WIDTH)) u_align (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .z       (z_q),
        .rdata   (mem.mem_rdata),
        .be      (be),
        .wdata   (wdata),
        .ld_data (ld_data)
    );

    assign mem.mem_req   = busy;
    assign mem.mem_we    = busy && is_store(op_q);
    assign mem.mem_addr  = busy ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign mem.mem_be    = busy ? be : 4'b0000;
    assign mem.mem_wdata = busy ? wdata : '0;

    always_comb begin
        state_nx = state;
        IsStall  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acc_ok) begin
                    state_nx = ST_BEAT0;
                    IsStall  = 1'b1;
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                // the abort cycle releases upstream so the failed op is not reissued
                IsStall = !tmo;
                if (mem.mem_ack)
                    state_nx = ((state == ST_BEAT0) && is_dword(op_q)) ? ST_BEAT1 : ST_DONE;
                else if (tmo)
                    state_nx = ST_IDLE;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ir_q   <= MEM_NOP;
            pc_q   <= '0;
            z_q    <= '0;
            addr_q <= '0;
            lo_q   <= '0;
            cnt    <= '0;
            IR_out <= MEM_NOP;
            PC_out <= '0;
            Z_out  <= '0;
            Z_hi   <= '0;
            MemErr <= 1'b0;
        end else begin
            state  <= state_nx;
            MemErr <= 1'b0;
            cnt    <= (busy && !mem.mem_ack && !tmo) ? cnt + CW'(1) : '0;
            case (state)
                ST_IDLE: begin
                    if (acc_ok) begin
                        ir_q   <= IR_in;
                        pc_q   <= PC_in;
                        z_q    <= Z_in;
                        addr_q <= Addr_in;
                        IR_out <= MEM_NOP;
                    end else if (acc_bad) begin
                        MemErr <= 1'b1;
                        IR_out <= MEM_NOP;
                    end else begin
                        IR_out <= IR_in;
                        PC_out <= PC_in;
                        Z_out  <= Z_in;
                        Z_hi   <= '0;
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (mem.mem_ack) begin
                        if ((state == ST_BEAT0) && is_dword(op_q)) begin
                            lo_q   <= ld_data;
                            addr_q <= addr_q + WIDTH'(4);
                        end else begin
                            IR_out <= ir_q;
                            PC_out <= pc_q;
                            if (is_store(op_q)) begin
                                Z_out <= z_q;
                                Z_hi  <= '0;
                            end else if (state == ST_BEAT1) begin
                                Z_out <= lo_q;
                                Z_hi  <= ld_data;
                            end else begin
                                Z_out <= ld_data;
                                Z_hi  <= '0;
                            end
                        end
                    end else if (tmo) begin
                        MemErr <= 1'b1;
                        IR_out <= MEM_NOP;
                    end
                end
                // writeback sees the finished op for exactly one cycle
                ST_DONE: IR_out <= MEM_NOP;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage against a byte-level memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int W  = 32;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   IR_in, Z_in, Addr_in, IR_out, Z_out, Z_hi;
    logic [W-3:0]   PC_in, PC_out;
    logic           IsStall, MemErr;
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [7:0]     smem [int unsigned];
    logic [7:0]     rmem [int unsigned];

    mem_stage_if #(.WIDTH(W)) mif ();

    mem_stage #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .IR_in   (IR_in),
        .PC_in   (PC_in),
        .Z_in    (Z_in),
        .Addr_in (Addr_in),
        .mem     (mif),
        .IR_out  (IR_out),
        .PC_out  (PC_out),
        .Z_out   (Z_out),
        .Z_hi    (Z_hi),
        .IsStall (IsStall),
        .MemErr  (MemErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seed_byte(input logic [31:0] a);
        return 8'((a * 32'd37) + 32'd11);
    endfunction

    function automatic logic [7:0] s_byte(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : seed_byte(a);
    endfunction

    function automatic logic [7:0] r_byte(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : seed_byte(a);
    endfunction

    function automatic logic [31:0] s_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = s_byte(a + 32'(i));
        return w;
    endfunction

    function automatic logic [31:0] r_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = r_byte(a + 32'(i));
        return w;
    endfunction

    task automatic s_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (be[i]) smem[a + 32'(i)] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            smem[a + 32'(i)] = d[8*i +: 8];
            rmem[a + 32'(i)] = d[8*i +: 8];
        end
    endtask

    function automatic int acc_bytes(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return 4;
            OP_LH, OP_SH: return 2;
            OP_LD, OP_SD: return 8;
            default:      return 0;
        endcase
    endfunction

    // lat = request cycles per beat up to and including the ack; 0 = never ack
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] z, input int lat);
        logic [31:0] ir, wa, exp_lo, exp_hi, exp_wd;
        logic [29:0] pc;
        logic [3:0]  exp_be;
        int          nb, nbeats, stall, lat_sum, h;
        bit          st;
        ir = {op, 26'($urandom)};
        pc = 30'($urandom);
        nb = acc_bytes(op);
        st = (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
        IR_in = ir; PC_in = pc; Z_in = z; Addr_in = addr;
        mif.mem_ack   = (nb == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        mif.mem_rdata = $urandom;
        #1;
        if (nb == 0) begin
            check("pass_stall", 64'(IsStall), 64'(0));
            check("pass_req", 64'(mif.mem_req), 64'(0));
            @(negedge clk);
            check("pass_ir", 64'(IR_out), 64'(ir));
            check("pass_pc", 64'(PC_out), 64'(pc));
            check("pass_z", 64'(Z_out), 64'(z));
            check("pass_zhi", 64'(Z_hi), 64'(0));
            check("pass_err", 64'(MemErr), 64'(0));
            return;
        end
        if ((addr % 32'(nb)) != 32'd0) begin
            check("mis_stall", 64'(IsStall), 64'(0));
            check("mis_req0", 64'(mif.mem_req), 64'(0));
            @(negedge clk);
            check("mis_err", 64'(MemErr), 64'(1));
            check("mis_ir", 64'(IR_out), 64'(MEM_NOP));
            check("mis_req1", 64'(mif.mem_req), 64'(0));
            IR_in = '0;
            @(negedge clk);
            check("mis_pulse", 64'(MemErr), 64'(0));
            return;
        end
        if (st) begin
            exp_lo = z;
            exp_hi = '0;
        end else if (nb == 2) begin
            h = int'({r_byte(addr + 32'd1), r_byte(addr)});
            if (h >= 32768) h = h - 65536;
            exp_lo = 32'(h);
            exp_hi = '0;
        end else begin
            exp_lo = r_word(addr);
            exp_hi = (nb == 8) ? r_word(addr + 32'd4) : 32'd0;
        end
        check("acc_stall", 64'(IsStall), 64'(1));
        check("acc_req", 64'(mif.mem_req), 64'(0));
        stall   = 1;
        lat_sum = 0;
        nbeats  = (nb == 8) ? 2 : 1;
        exp_be  = (nb == 2) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        exp_wd  = (nb == 2) ? {2{z[15:0]}} : z;
        for (int b = 0; b < nbeats; b++) begin
            wa = (addr & 32'hFFFF_FFFC) + 32'(4 * b);
            for (int c = 0; c < ((lat == 0) ? TO : lat); c++) begin
                @(negedge clk);
                mif.mem_ack = 1'b0;
                #1;
                check("beat_req", 64'(mif.mem_req), 64'(1));
                check("beat_addr", 64'(mif.mem_addr), 64'(wa));
                check("beat_be", 64'(mif.mem_be), 64'(exp_be));
                check("beat_we", 64'(mif.mem_we), 64'(st));
                if (st) check("beat_wdata", 64'(mif.mem_wdata), 64'(exp_wd));
                if (IsStall) stall++;
                if (lat != 0 && c == lat - 1) begin
                    mif.mem_rdata = s_word(wa);
                    if (st) s_write(wa, mif.mem_be, mif.mem_wdata);
                    mif.mem_ack = 1'b1;
                end
            end
            lat_sum += lat;
        end
        if (lat == 0) begin
            @(negedge clk);
            #1;
            check("to_req", 64'(mif.mem_req), 64'(0));
            check("to_err", 64'(MemErr), 64'(1));
            check("to_ir", 64'(IR_out), 64'(MEM_NOP));
            check("to_stallcnt", 64'(stall), 64'(TO));
            IR_in = '0;
            @(negedge clk);
            check("to_pulse", 64'(MemErr), 64'(0));
            return;
        end
        @(negedge clk);
        mif.mem_ack = 1'($urandom_range(0, 1));
        #1;
        check("done_stall", 64'(IsStall), 64'(0));
        check("done_req", 64'(mif.mem_req), 64'(0));
        check("done_ir", 64'(IR_out), 64'(ir));
        check("done_pc", 64'(PC_out), 64'(pc));
        check("done_z", 64'(Z_out), 64'(exp_lo));
        check("done_zhi", 64'(Z_hi), 64'(exp_hi));
        check("done_err", 64'(MemErr), 64'(0));
        check("done_stallcnt", 64'(stall), 64'(1 + lat_sum));
        if (st)
            for (int i = 0; i < nb; i++) rmem[addr + 32'(i)] = z[8*(i % 4) +: 8];
        @(negedge clk);
        mif.mem_ack = 1'b0;
        #1;
        check("after_ir", 64'(IR_out), 64'(MEM_NOP));
        check("after_req", 64'(mif.mem_req), 64'(0));
    endtask

    initial begin
        logic [5:0]  op_tab [11];
        logic [31:0] a;
        int          off;
        op_tab = '{OP_NOP, OP_ADD, OP_SUB, OP_BEQ, OP_HALT,
                   OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};
        IR_in = '0; PC_in = '0; Z_in = '0; Addr_in = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        rst_n = 1'b0;
        #12;
        check("rst_ir", 64'(IR_out), 64'(MEM_NOP));
        check("rst_pc", 64'(PC_out), 64'(0));
        check("rst_z", 64'(Z_out), 64'(0));
        check("rst_zhi", 64'(Z_hi), 64'(0));
        check("rst_req", 64'(mif.mem_req), 64'(0));
        check("rst_stall", 64'(IsStall), 64'(0));
        check("rst_err", 64'(MemErr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_ADD, 32'h0, 32'h0000_0007, 1);
        preload(32'h100, 32'hDEAD_BEEF);
        run_op(OP_LW, 32'h100, $urandom, 4);
        preload(32'h100, 32'h8001_1234);
        run_op(OP_LH, 32'h102, $urandom, 2);
        run_op(OP_SH, 32'h200, 32'h0000_ABCD, 2);
        preload(32'h108, 32'h1111_2222);
        preload(32'h10C, 32'h3333_4444);
        run_op(OP_LD, 32'h108, $urandom, 2);
        run_op(OP_LW, 32'h101, $urandom, 1);
        run_op(OP_SH, 32'h203, $urandom, 1);
        run_op(OP_SD, 32'h204, $urandom, 1);
        run_op(OP_LW, 32'h200, $urandom, 1);
        run_op(OP_SD, 32'h210, 32'hCAFE_F00D, 3);
        run_op(OP_LD, 32'h210, $urandom, 1);
        run_op(OP_SW, 32'h220, $urandom, 0);

        for (int i = 0; i < 40; i++) begin
            off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                              : int'(4 * $urandom_range(0, 1));
            a = 32'h300 + 32'(8 * $urandom_range(0, 7)) + 32'(off);
            run_op(op_tab[$urandom_range(0, 10)], a, $urandom, int'($urandom_range(1, 4)));
        end

        IR_in = {OP_SW, 26'h0}; Addr_in = 32'h400; Z_in = 32'h1234_5678; PC_in = 30'h5;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_req", 64'(mif.mem_req), 64'(1));
        IR_in = '0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 64'(mif.mem_req), 64'(0));
        check("mid_rst_addr", 64'(mif.mem_addr), 64'(0));
        check("mid_rst_be", 64'(mif.mem_be), 64'(0));
        check("mid_rst_we", 64'(mif.mem_we), 64'(0));
        check("mid_rst_stall", 64'(IsStall), 64'(0));
        check("mid_rst_ir", 64'(IR_out), 64'(MEM_NOP));
        check("mid_rst_z", 64'(Z_out), 64'(0));
        check("mid_rst_pc", 64'(PC_out), 64'(0));
        check("mid_rst_err", 64'(MemErr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("no_retry_req", 64'(mif.mem_req), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes IR, PC, ALU result Z and effective address Addr.
- Performs loads and stores through a req/ack data-memory port, and forwards ALU results unchanged for non-memory ops.
- Drives IsStall back to the execute and upstream stages while a memory access is outstanding.

Parameters:
- WIDTH, 32, datapath width; PC width is WIDTH-2.
- TIMEOUT, 64, cycles without mem_ack before the access is aborted.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IR_in  in  WIDTH  instruction from the execute stage.
- PC_in  in  WIDTH-2  PC from the execute stage.
- Z_in  in  WIDTH  ALU result or store data.
- Addr_in  in  WIDTH  effective byte address for loads and stores.
- mem_req  out  1  memory request, held high until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  WIDTH  word-aligned byte address.
- mem_be  out  4  byte enables.
- mem_wdata  out  WIDTH  lane-steered write data.
- mem_ack  in  1  single-cycle completion strobe.
- mem_rdata  in  WIDTH  read data, valid with mem_ack.
- IR_out  out  WIDTH  registered IR to writeback.
- PC_out  out  WIDTH-2  registered PC.
- Z_out  out  WIDTH  load data (sign-extended for LH) or passthrough Z.
- Z_hi  out  WIDTH  upper word of LD, else 0.
- IsStall  out  1  upstream hold.
- MemErr  out  1  one-cycle pulse on misalign or timeout.

Behaviour:
- Reset: all outputs go to 0; IR_out = NOP encoding; FSM = IDLE; timeout counter = 0.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE, non-memory opcode (including NOP, HALT, branches): register IR/PC/Z to the outputs next edge; IsStall = 0. Latency is 1 cycle.
- IDLE, memory opcode (LW, LH, LD, SW, SH, SD):
  - Check alignment: LW/SW need Addr[1:0]=0, LH/SH need Addr[0]=0, LD/SD need Addr[2:0]=0.
  - Misaligned: no request is issued; pulse MemErr; IR_out = NOP; stay in IDLE.
  - Aligned: capture IR/PC/Z/Addr, go to BEAT0, and assert IsStall combinationally in that same cycle. IsStall stays high until the DONE state.
- BEAT0:
  - Outputs: mem_req=1; mem_addr={Addr[W-1:2],2'b00}; mem_we=1 for stores.
  - mem_be: word = 4'b1111; half = 4'b0011 when Addr[1]=0, 4'b1100 when Addr[1]=1.
  - SH replicates Z[15:0] into both halves of mem_wdata.
  - On mem_ack: LD/SD go to BEAT1 at Addr+4; all others go to DONE.
  - Load data is captured on ack. LH takes the selected half and sign-extends it to WIDTH.
- BEAT1: second word. For SD, mem_wdata = Z of the following beat is not available, so SD writes Z to both words. For LD, the second word goes to Z_hi. On mem_ack go to DONE.
- mem_req/mem_addr/mem_be/mem_wdata/mem_we hold stable while mem_req=1 and mem_ack=0.
- DONE: drive outputs (stores emit Z_out=Z, Z_hi=0); IsStall=0; return to IDLE. A new op is accepted in the next cycle. Total access latency is ack latency + 2 cycles.
- Timeout: the counter increments each cycle in BEAT0/BEAT1 and clears on ack. When it reaches TIMEOUT-1: drop mem_req, pulse MemErr, IR_out = NOP, go to IDLE.
- A mem_ack seen in IDLE or DONE is ignored.
- Reset asserted mid-access drops mem_req asynchronously; no retry after reset.

Decomposition:
- Opcode defines come from the shared ISA header; WIDTH comes from the shared params header.
- Add FSM state localparams and a MEM_NOP constant to the params header.
- One sub-module, mem_align (combinational): takes op, Addr[1:0] and data, and produces mem_be, steered wdata, and load extraction/sign-extension.

Test Plan:
- ADD, Z_in=0x00000007 -> next cycle Z_out=0x00000007, IsStall=0, mem_req never asserted.
- LW at Addr=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> mem_be=1111 and address held for 3 cycles; Z_out=0xDEADBEEF; IsStall high for 5 cycles.
- LH at Addr=0x102, rdata=0x8001_1234 -> mem_be=1100; Z_out=0xFFFF8001.
- SH at Addr=0x200, Z=0x0000ABCD -> mem_we=1, mem_be=0011, mem_wdata=0xABCDABCD.
- LD at Addr=0x108 -> two beats at 0x108 and 0x10C; Z_out = word0, Z_hi = word1. LW at Addr=0x101 -> no mem_req, MemErr pulses for 1 cycle, IR_out=NOP.
- SW with mem_ack never returned (TIMEOUT=64) -> MemErr after 64 cycles, mem_req dropped. Separately, reset asserted during BEAT0 -> mem_req=0 immediately and all outputs at reset values.
